// File: rtl/receiver_fifo_if.sv
// Sender (Request/Ack) and consumer (Ready/Pop) signal bundle for receiver_fifo.
interface receiver_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  logic                         Request;
  logic [WIDTH-1:0]             rcvDataIn;
  logic                         Ack;
  logic                         Pop;
  logic                         Ready;
  logic [WIDTH-1:0]             rcvDataOut;
  logic                         Full;
  logic [$clog2(DEPTH+1)-1:0]   Count;

  modport slave (
    input  Request, rcvDataIn, Pop,
    output Ack, Ready, rcvDataOut, Full, Count
  );

  modport master (
    output Request, rcvDataIn, Pop,
    input  Ack, Ready, rcvDataOut, Full, Count
  );
endinterface

// File: rtl/receiver_fifo.sv
// Four-phase Request/Ack receiver feeding a DEPTH-entry FIFO drained via Ready/Pop.
module receiver_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            Reset,
  receiver_fifo_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic [1:0] {SYNC = 2'd0, IDLE = 2'd1, ACK = 2'd2} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_ack;
  logic             w_ready, w_full, w_pop, w_wr;

  assign w_ready = (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_pop   = bus.Pop && w_ready;
  // A full FIFO still accepts a word when the head leaves on the same edge.
  assign w_wr    = (r_state == IDLE) && bus.Request && (!w_full || w_pop);

  always_comb begin
    w_next = r_state;
    case (r_state)
      SYNC:    if (!bus.Request) w_next = IDLE;
      IDLE:    if (w_wr)         w_next = ACK;
      ACK:     if (!bus.Request) w_next = IDLE;
      default:                   w_next = SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state  <= SYNC;
      r_ack    <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_state <= w_next;
      r_ack   <= (w_next == ACK);
      if (w_wr) begin
        r_mem[r_wr_ptr] <= bus.rcvDataIn;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_wr && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_wr && w_pop) r_count <= r_count - CW'(1);
    end
  end

  assign bus.Ack        = r_ack;
  assign bus.Ready      = w_ready;
  assign bus.Full       = w_full;
  assign bus.Count      = r_count;
  assign bus.rcvDataOut = r_mem[r_rd_ptr];
endmodule
